// File: rtl/target_way_arbiter_pkg.sv
// rtl/target_way_arbiter_pkg.sv - shared constants and encodings for the target way arbiter
// Purpose: target count, field widths, operation type and FSM state encodings
//          shared by the arbiter top and its round-robin picker.
package target_way_arbiter_pkg;

   localparam int NUM_TARGETS = 8;
   localparam int TARGET_AW   = 3;
   localparam int OP_TYPE_W   = 3;

   typedef enum logic [OP_TYPE_W-1:0] {
      OP_NOP         = 3'd0,
      OP_READ        = 3'd1,
      OP_PROGRAM     = 3'd2,
      OP_ERASE       = 3'd3,
      OP_RESET       = 3'd4,
      OP_READ_STATUS = 3'd5,
      OP_READ_ID     = 3'd6,
      OP_SET_FEATURE = 3'd7
   } op_type_e;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_BUSY = 2'd2
   } arb_state_e;

endpackage

// File: rtl/target_way_arbiter_rr_priority_pick.sv
// rtl/target_way_arbiter_rr_priority_pick.sv - round-robin rotate and priority encode
// Purpose: picks the first set bit of the eligible mask, searching from
//          last_grant+1 upward and wrapping modulo NUM_TARGETS.
// Ports:
//   i_eligible   in  NUM_TARGETS  targets that may be granted
//   i_last_grant in  TARGET_AW    most recently granted target
//   o_grant      out TARGET_AW    chosen target (0 when none found)
//   o_found      out 1            at least one eligible target
module rr_priority_pick
   import target_way_arbiter_pkg::*;
(
   input  logic [NUM_TARGETS-1:0] i_eligible,
   input  logic [TARGET_AW-1:0]   i_last_grant,
   output logic [TARGET_AW-1:0]   o_grant,
   output logic                   o_found
);

   logic [TARGET_AW-1:0] w_idx;

   // Walk from the farthest candidate back to the nearest so the nearest
   // eligible target after last_grant is the final assignment. The 3-bit
   // add wraps naturally; offset 8 lands on last_grant itself.
   always_comb begin
      o_grant = '0;
      o_found = 1'b0;
      w_idx   = '0;
      for (int k = NUM_TARGETS; k >= 1; k--) begin
         w_idx = i_last_grant + TARGET_AW'(k);
         if (i_eligible[w_idx]) begin
            o_grant = w_idx;
            o_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/target_way_arbiter.sv
// rtl/target_way_arbiter.sv - round-robin arbiter/sequencer for the shared flash command port
// Purpose: one pending op per target; tracks per-target ready/busy (synchronized
//          RB_L plus a tWB blanking window); issues one Operation_en at a time
//          when the controller is idle and the chosen target is ready.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid[8]        per-target request, held until req_ack
//   req_type[24]        packed 8x3 op type, target t at [3t+2:3t]
//   req_addr[8*PAGE_AW] packed per-target page/offset address
//   req_ack[8]          one-cycle pulse when target t is issued
//   RB_L[8]             raw asynchronous ready/busy pins, low = busy
//   controller_rb_l     high = flash_controller idle
//   read_data_stall     high = inhibit new issue
//   Operation_en        one-cycle issue strobe
//   Operation_Type      registered type of the issued op
//   Target_Addr         registered target index
//   page_offset_addr    registered address
//   target_busy[8]      per-target busy status
//   issue_timeout       sticky: controller never acknowledged an issue
module target_way_arbiter
   import target_way_arbiter_pkg::*;
#(
   parameter int PAGE_AW     = 24,
   parameter int TWB_CYCLES  = 20,
   parameter int ACK_TIMEOUT = 31
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_TARGETS-1:0]         req_valid,
   input  logic [NUM_TARGETS*OP_TYPE_W-1:0] req_type,
   input  logic [NUM_TARGETS*PAGE_AW-1:0] req_addr,
   output logic [NUM_TARGETS-1:0]         req_ack,
   input  logic [NUM_TARGETS-1:0]         RB_L,
   input  logic                           controller_rb_l,
   input  logic                           read_data_stall,
   output logic                           Operation_en,
   output logic [OP_TYPE_W-1:0]           Operation_Type,
   output logic [TARGET_AW-1:0]           Target_Addr,
   output logic [PAGE_AW-1:0]             page_offset_addr,
   output logic [NUM_TARGETS-1:0]         target_busy,
   output logic                           issue_timeout
);

   localparam int BLANK_W = 5;
   localparam int WAIT_W  = $clog2(ACK_TIMEOUT + 1);

   logic [NUM_TARGETS-1:0] r_rb_meta;
   logic [NUM_TARGETS-1:0] r_rb_sync;
   logic [NUM_TARGETS-1:0] r_busy;
   logic [NUM_TARGETS-1:0] r_req_ack;
   logic [BLANK_W-1:0]     r_blank_cnt [NUM_TARGETS];
   arb_state_e             r_state;
   logic [TARGET_AW-1:0]   r_last_grant;
   logic [TARGET_AW-1:0]   r_target;
   logic [OP_TYPE_W-1:0]   r_op_type;
   logic [PAGE_AW-1:0]     r_addr;
   logic [WAIT_W-1:0]      r_wait_cnt;
   logic                   r_op_en;
   logic                   r_timeout;

   logic [NUM_TARGETS-1:0] w_eligible;
   logic [NUM_TARGETS-1:0] w_busy_next;
   logic [TARGET_AW-1:0]   w_grant;
   logic                   w_found;
   logic                   w_arbitrate;
   logic [OP_TYPE_W-1:0]   w_sel_type;
   logic [PAGE_AW-1:0]     w_sel_addr;

   assign w_eligible  = req_valid & ~r_busy;
   assign w_arbitrate = controller_rb_l & ~read_data_stall & w_found;

   rr_priority_pick u_pick (
      .i_eligible   (w_eligible),
      .i_last_grant (r_last_grant),
      .o_grant      (w_grant),
      .o_found      (w_found)
   );

   always_comb begin
      w_busy_next = '0;
      w_sel_type  = '0;
      w_sel_addr  = '0;
      for (int t = 0; t < NUM_TARGETS; t++) begin
         w_busy_next[t] = (r_blank_cnt[t] != '0) | ~r_rb_sync[t];
         if (w_grant == TARGET_AW'(t)) begin
            w_sel_type = req_type[t*OP_TYPE_W +: OP_TYPE_W];
            w_sel_addr = req_addr[t*PAGE_AW +: PAGE_AW];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rb_meta    <= '1;
         r_rb_sync    <= '1;
         r_busy       <= '0;
         r_req_ack    <= '0;
         r_state      <= ST_IDLE;
         r_last_grant <= TARGET_AW'(NUM_TARGETS - 1);
         r_target     <= '0;
         r_op_type    <= '0;
         r_addr       <= '0;
         r_wait_cnt   <= '0;
         r_op_en      <= 1'b0;
         r_timeout    <= 1'b0;
         for (int t = 0; t < NUM_TARGETS; t++) begin
            r_blank_cnt[t] <= '0;
         end
      end else begin
         r_rb_meta <= RB_L;
         r_rb_sync <= r_rb_meta;
         r_busy    <= w_busy_next;
         r_op_en   <= 1'b0;
         r_req_ack <= '0;

         // Reload on issue wins over the free-running decrement.
         for (int t = 0; t < NUM_TARGETS; t++) begin
            if (r_state == ST_ISSUE && r_target == TARGET_AW'(t)) begin
               r_blank_cnt[t] <= BLANK_W'(TWB_CYCLES);
            end else if (r_blank_cnt[t] != '0) begin
               r_blank_cnt[t] <= r_blank_cnt[t] - BLANK_W'(1);
            end
         end

         case (r_state)
            ST_IDLE: begin
               if (w_arbitrate) begin
                  r_op_type    <= w_sel_type;
                  r_target     <= w_grant;
                  r_addr       <= w_sel_addr;
                  r_last_grant <= w_grant;
                  r_op_en      <= 1'b1;
                  r_req_ack    <= NUM_TARGETS'(1) << w_grant;
                  r_state      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_wait_cnt <= '0;
               r_state    <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               if (!controller_rb_l) begin
                  r_state <= ST_IDLE;
               end else if (r_wait_cnt == WAIT_W'(ACK_TIMEOUT)) begin
                  r_timeout <= 1'b1;
                  r_state   <= ST_IDLE;
               end else begin
                  r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ack          = r_req_ack;
   assign Operation_en     = r_op_en;
   assign Operation_Type   = r_op_type;
   assign Target_Addr      = r_target;
   assign page_offset_addr = r_addr;
   assign target_busy      = r_busy;
   assign issue_timeout    = r_timeout;

endmodule
